// File: rtl/sap1_pkg.sv
// sap1_pkg - shared definitions for the SAP-1 core.
//   state_e      : control unit state encodings (FETCH/DECODE/EXECUTE/illegal)
//   OP_*         : 4-bit opcode constants carried in the IR high nibble
//   OPCODE_W     : opcode field width
//   OPERAND_LSB  : low bit of the operand field (the operand is ADDR_W wide)
package sap1_pkg;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'b00,
    ST_DECODE  = 2'b01,
    ST_EXECUTE = 2'b10,
    ST_ILLEGAL = 2'b11
  } state_e;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_XOR = 4'h7;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JZ  = 4'h9;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // IR field layout: opcode = ir[DATA_W-1 -: OPCODE_W], operand = ir[OPERAND_LSB +: ADDR_W]
  localparam int OPCODE_W    = 4;
  localparam int OPERAND_LSB = 0;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// instruction_fetch_unit_if - bundles the control-unit, RAM and debug signals
// of the instruction fetch unit.
//   master : fetch unit side (drives mem_addr, opcode, operand, pc, halted, instr_count)
//   slave  : control unit / RAM / observer side (drives state, pc_inc, pc_jmp,
//            mem_read, mem_data)
interface instruction_fetch_unit_if
  import sap1_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
);

  logic [1:0]          state;
  logic                pc_inc;
  logic                pc_jmp;
  logic                mem_read;
  logic [DATA_W-1:0]   mem_data;
  logic [ADDR_W-1:0]   mem_addr;
  logic [OPCODE_W-1:0] opcode;
  logic [ADDR_W-1:0]   operand;
  logic [ADDR_W-1:0]   pc;
  logic                halted;
  logic [CNT_W-1:0]    instr_count;

  modport master (
    input  state, pc_inc, pc_jmp, mem_read, mem_data,
    output mem_addr, opcode, operand, pc, halted, instr_count
  );

  modport slave (
    output state, pc_inc, pc_jmp, mem_read, mem_data,
    input  mem_addr, opcode, operand, pc, halted, instr_count
  );

endinterface

// File: rtl/program_counter.sv
// program_counter - ADDR_W-bit program counter.
//   clk      in  : clock
//   reset    in  : asynchronous active-high reset, pc -> 0
//   inc      in  : pc <- pc + 1 (wraps modulo 2^ADDR_W)
//   load     in  : pc <- load_val, wins over inc
//   load_val in  : jump target
//   pc       out : current program counter
module program_counter #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] pc_next;

  always_comb begin
    pc_next = pc_reg;
    if (load) begin
      pc_next = load_val;
    end else if (inc) begin
      pc_next = pc_reg + 1'b1;  // natural overflow gives the 15 -> 0 wrap
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg <= '0;
    end else begin
      pc_reg <= pc_next;
    end
  end

  assign pc = pc_reg;

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit - PC, IR, halt detection and executed-instruction
// counter of the SAP-1 core; drives the program/data RAM address.
//   clk   in : clock, all state changes on the rising edge
//   reset in : asynchronous active-high reset
//   bus       (master modport of instruction_fetch_unit_if):
//     state/pc_inc/pc_jmp/mem_read in : control unit commands
//     mem_data in                     : RAM read data (combinational)
//     mem_addr out                    : RAM address (operand for EXECUTE reads, else pc)
//     opcode/operand out              : IR fields
//     pc out, halted out              : program counter, sticky HLT flag
//     instr_count out                 : completed EXECUTE cycles, saturating
module instruction_fetch_unit
  import sap1_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  instruction_fetch_unit_if.master  bus
);

  state_e            state;
  logic [DATA_W-1:0] ir_reg;
  logic [DATA_W-1:0] ir_next;
  logic              halted_reg;
  logic              halted_next;
  logic [CNT_W-1:0]  count_reg;
  logic [CNT_W-1:0]  count_next;

  logic [OPCODE_W-1:0] opcode;
  logic [ADDR_W-1:0]   operand;
  logic [ADDR_W-1:0]   pc;
  logic                is_fetch;
  logic                is_exec;
  logic                run_exec;

  assign state    = state_e'(bus.state);
  assign is_fetch = (state == ST_FETCH);
  assign is_exec  = (state == ST_EXECUTE);
  // Every architectural update in EXECUTE is gated by the halt flag.
  assign run_exec = is_exec && !halted_reg;

  assign opcode  = ir_reg[DATA_W-1 -: OPCODE_W];
  assign operand = ir_reg[OPERAND_LSB +: ADDR_W];

  program_counter #(
    .ADDR_W (ADDR_W)
  ) u_program_counter (
    .clk      (clk),
    .reset    (reset),
    .inc      (run_exec && bus.pc_inc),
    .load     (run_exec && bus.pc_jmp),
    .load_val (operand),
    .pc       (pc)
  );

  always_comb begin
    ir_next     = ir_reg;
    halted_next = halted_reg;
    count_next  = count_reg;
    if (is_fetch && bus.mem_read && !halted_reg) begin
      ir_next = bus.mem_data;
    end
    // HLT sets the flag on its own EXECUTE edge; nothing clears it but reset.
    if (is_exec && opcode == OP_HLT) begin
      halted_next = 1'b1;
    end
    if (run_exec && count_reg != {CNT_W{1'b1}}) begin
      count_next = count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_reg     <= '0;
      halted_reg <= 1'b0;
      count_reg  <= '0;
    end else begin
      ir_reg     <= ir_next;
      halted_reg <= halted_next;
      count_reg  <= count_next;
    end
  end

  // Data reads in EXECUTE address the operand; everything else addresses the PC.
  assign bus.mem_addr    = (is_exec && bus.mem_read) ? operand : pc;
  assign bus.opcode      = opcode;
  assign bus.operand     = operand;
  assign bus.pc          = pc;
  assign bus.halted      = halted_reg;
  assign bus.instr_count = count_reg;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit - scoreboard bench for instruction_fetch_unit.
// Expectations are queued when a cycle is set up and compared either just
// before the closing edge (combinational mem_addr) or 1 time unit after it.
module tb_instruction_fetch_unit;
  import sap1_pkg::*;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 8;

  typedef enum int {S_PC, S_OPC, S_OPR, S_HALT, S_CNT, S_ADDR} sel_e;
  typedef struct {
    sel_e        sel;
    logic [31:0] val;
    string       tag;
  } exp_t;

  logic clk;
  logic reset;
  logic [DATA_W-1:0] ram [16];

  exp_t pre_q[$];
  exp_t post_q[$];
  int   n_checks;
  int   n_fail;

  instruction_fetch_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  instruction_fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  assign bus.mem_data = ram[bus.mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic logic [31:0] obs(input sel_e s);
    case (s)
      S_PC:    return 32'(bus.pc);
      S_OPC:   return 32'(bus.opcode);
      S_OPR:   return 32'(bus.operand);
      S_HALT:  return 32'(bus.halted);
      S_CNT:   return 32'(bus.instr_count);
      default: return 32'(bus.mem_addr);
    endcase
  endfunction

  task automatic exp_pre(input sel_e s, input logic [31:0] v, input string tag);
    exp_t e;
    e.sel = s; e.val = v; e.tag = tag;
    pre_q.push_back(e);
  endtask

  task automatic exp_post(input sel_e s, input logic [31:0] v, input string tag);
    exp_t e;
    e.sel = s; e.val = v; e.tag = tag;
    post_q.push_back(e);
  endtask

  task automatic drain_pre();
    exp_t e;
    while (pre_q.size() > 0) begin
      e = pre_q.pop_front();
      check_eq(e.tag, obs(e.sel), e.val);
    end
  endtask

  task automatic drain_post();
    exp_t e;
    while (post_q.size() > 0) begin
      e = post_q.pop_front();
      check_eq(e.tag, obs(e.sel), e.val);
    end
  endtask

  // One control-unit cycle: drive at the falling edge, check comb outputs
  // before the rising edge and registered outputs just after it.
  task automatic cycle(input logic [1:0] st, input logic inc, input logic jmp, input logic rd);
    @(negedge clk);
    bus.state    = st;
    bus.pc_inc   = inc;
    bus.pc_jmp   = jmp;
    bus.mem_read = rd;
    #1 drain_pre();
    @(posedge clk);
    #1 drain_post();
    $display("cycle st=%0d inc=%0b jmp=%0b rd=%0b -> pc=%0h ir=%0h%0h halted=%0b cnt=%0d",
             st, inc, jmp, rd, bus.pc, bus.opcode, bus.operand, bus.halted, bus.instr_count);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.state = ST_FETCH;
    #1;
    exp_pre(S_PC, 0, "rst_pc");
    exp_pre(S_HALT, 0, "rst_halt");
    exp_pre(S_CNT, 0, "rst_cnt");
    drain_pre();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 16; i++) ram[i] = 8'h00;
    reset        = 1'b1;
    bus.state    = ST_FETCH;
    bus.pc_inc   = 1'b0;
    bus.pc_jmp   = 1'b0;
    bus.mem_read = 1'b0;

    // Reset state
    #12;
    exp_pre(S_PC, 0, "reset_pc");
    exp_pre(S_OPC, 0, "reset_opcode");
    exp_pre(S_OPR, 0, "reset_operand");
    exp_pre(S_HALT, 0, "reset_halted");
    exp_pre(S_CNT, 0, "reset_count");
    exp_pre(S_ADDR, 0, "reset_mem_addr");
    drain_pre();
    @(negedge clk);
    reset = 1'b0;

    // Basic fetch of 0x1A and an operand read in EXECUTE
    ram[0] = 8'h1A;
    ram[1] = 8'h8F;
    ram[15] = 8'h25;
    exp_pre(S_ADDR, 0, "t1_fetch_addr");
    exp_post(S_OPC, 1, "t1_opcode");
    exp_post(S_OPR, 4'hA, "t1_operand");
    exp_post(S_PC, 0, "t1_pc_hold");
    cycle(ST_FETCH, 0, 0, 1);
    exp_pre(S_ADDR, 0, "t1_decode_addr");
    exp_post(S_OPC, 1, "t1_decode_opcode");
    cycle(ST_DECODE, 0, 0, 0);
    exp_pre(S_ADDR, 4'hA, "t1_exec_addr");
    exp_post(S_PC, 1, "t1_pc_inc");
    exp_post(S_CNT, 1, "t1_count");
    cycle(ST_EXECUTE, 1, 0, 1);

    // Jump to 15, then wrap 15 -> 0
    exp_pre(S_ADDR, 1, "t2_fetch_addr");
    exp_post(S_OPC, 8, "t2_opcode");
    exp_post(S_OPR, 4'hF, "t2_operand");
    cycle(ST_FETCH, 0, 0, 1);
    cycle(ST_DECODE, 0, 0, 0);
    exp_pre(S_ADDR, 1, "t2_exec_noread_addr");
    exp_post(S_PC, 4'hF, "t2_jmp_pc");
    exp_post(S_CNT, 2, "t2_count");
    cycle(ST_EXECUTE, 0, 1, 0);
    exp_pre(S_ADDR, 4'hF, "t2_fetch15_addr");
    exp_post(S_OPR, 5, "t2_operand5");
    cycle(ST_FETCH, 0, 0, 1);
    cycle(ST_DECODE, 0, 0, 0);
    exp_pre(S_ADDR, 5, "t2_exec_addr5");
    exp_post(S_PC, 0, "t2_wrap_pc");
    exp_post(S_CNT, 3, "t2_count3");
    cycle(ST_EXECUTE, 1, 0, 1);

    // Jump priority over increment
    ram[0] = 8'h85;
    exp_post(S_OPC, 8, "t2b_opcode");
    cycle(ST_FETCH, 0, 0, 1);
    cycle(ST_DECODE, 0, 0, 0);
    exp_post(S_PC, 5, "t2b_jmp_prio_pc");
    exp_post(S_CNT, 4, "t2b_count4");
    cycle(ST_EXECUTE, 1, 1, 0);

    // pc_inc ignored in FETCH/DECODE; illegal state changes nothing
    ram[5] = 8'h33;
    exp_post(S_PC, 5, "t3_fetch_inc_pc");
    exp_post(S_OPC, 3, "t3_opcode");
    cycle(ST_FETCH, 1, 0, 1);
    exp_post(S_PC, 5, "t3_decode_inc_pc");
    cycle(ST_DECODE, 1, 1, 0);
    ram[5] = 8'h77;
    exp_pre(S_ADDR, 5, "t3_illegal_addr");
    exp_post(S_OPC, 3, "t3_illegal_opcode");
    exp_post(S_OPR, 3, "t3_illegal_operand");
    exp_post(S_PC, 5, "t3_illegal_pc");
    exp_post(S_CNT, 4, "t3_illegal_count");
    cycle(ST_ILLEGAL, 1, 1, 1);
    exp_post(S_PC, 6, "t3_exec_pc");
    exp_post(S_CNT, 5, "t3_exec_count");
    cycle(ST_EXECUTE, 1, 0, 0);

    // LDA, ADD, HLT program
    do_reset();
    ram[0] = 8'h1E;
    ram[1] = 8'h2F;
    ram[2] = 8'hF0;
    for (int k = 1; k <= 2; k++) begin
      cycle(ST_FETCH, 0, 0, 1);
      cycle(ST_DECODE, 0, 0, 0);
      exp_post(S_PC, k, $sformatf("t4_pc_%0d", k));
      exp_post(S_HALT, 0, $sformatf("t4_halt_%0d", k));
      cycle(ST_EXECUTE, 1, 0, 1);
    end
    exp_post(S_OPC, 4'hF, "t4_hlt_opcode");
    cycle(ST_FETCH, 0, 0, 1);
    exp_post(S_HALT, 0, "t4_halt_decode");
    cycle(ST_DECODE, 0, 0, 0);
    exp_post(S_HALT, 1, "t4_halted");
    exp_post(S_CNT, 3, "t4_hlt_count");
    exp_post(S_PC, 2, "t4_hlt_pc");
    cycle(ST_EXECUTE, 0, 0, 0);
    ram[2] = 8'h13;
    for (int k = 0; k < 10; k++) begin
      if (k % 3 == 2) exp_pre(S_ADDR, 0, $sformatf("t4_frz_addr_%0d", k));
      else            exp_pre(S_ADDR, 2, $sformatf("t4_frz_addr_%0d", k));
      exp_post(S_PC, 2, $sformatf("t4_frz_pc_%0d", k));
      exp_post(S_CNT, 3, $sformatf("t4_frz_cnt_%0d", k));
      exp_post(S_HALT, 1, $sformatf("t4_frz_halt_%0d", k));
      exp_post(S_OPC, 4'hF, $sformatf("t4_frz_opc_%0d", k));
      cycle(2'(k % 3), 1, 1, 1);
    end

    // Async reset during DECODE with pc=7, then refetch from 0
    do_reset();
    ram[0] = 8'h87;
    ram[7] = 8'h87;
    cycle(ST_FETCH, 0, 0, 1);
    cycle(ST_DECODE, 0, 0, 0);
    exp_post(S_PC, 7, "t5_pc7");
    cycle(ST_EXECUTE, 0, 1, 0);
    exp_post(S_OPC, 8, "t5_opc8");
    cycle(ST_FETCH, 0, 0, 1);
    @(negedge clk);
    bus.state = ST_DECODE;
    bus.mem_read = 1'b0;
    #2 reset = 1'b1;
    #1;
    exp_pre(S_PC, 0, "t5_async_pc");
    exp_pre(S_OPC, 0, "t5_async_opcode");
    exp_pre(S_CNT, 0, "t5_async_count");
    exp_pre(S_HALT, 0, "t5_async_halted");
    drain_pre();
    $display("async reset during DECODE -> pc=%0h opcode=%0h cnt=%0d", bus.pc, bus.opcode, bus.instr_count);
    @(negedge clk);
    reset = 1'b0;
    exp_pre(S_ADDR, 0, "t5_refetch_addr");
    exp_post(S_OPR, 7, "t5_refetch_operand");
    cycle(ST_FETCH, 0, 0, 1);
    cycle(ST_DECODE, 0, 0, 0);
    exp_post(S_PC, 7, "t5_refetch_pc");
    cycle(ST_EXECUTE, 0, 1, 0);

    // JMP-to-self loop: counter saturates
    for (int n = 2; n <= 300; n++) begin
      cycle(ST_FETCH, 0, 0, 1);
      cycle(ST_DECODE, 0, 0, 0);
      exp_post(S_PC, 7, $sformatf("t6_pc_%0d", n));
      exp_post(S_CNT, (n > 255) ? 255 : n, $sformatf("t6_cnt_%0d", n));
      cycle(ST_EXECUTE, 1, 1, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Holds the program counter (PC) and instruction register (IR) for the SAP-1 core, and drives the address port of the 16×8 program/data RAM. It sits directly upstream of the control unit:
- consumes the control unit's `pc_inc`, `pc_jmp`, `mem_read` and `state`;
- returns `opcode` to it;
- supplies `operand` to the datapath.

It also detects HLT, freezes the machine and keeps an executed-instruction count for debug.

## Interface
Parameters:
- `ADDR_W`, default 4, RAM address and PC width.
- `DATA_W`, default 8, RAM word width. The IR splits the word as opcode = `[DATA_W-1:DATA_W-4]` and operand = `[ADDR_W-1:0]`.
- `CNT_W`, default 8, width of the instruction counter.

Ports:
- `clk` in 1: the single clock. All state changes on the rising edge.
- `reset` in 1: asynchronous, active-high. Returns all registers to reset values immediately.
- `state` in 2: control unit state. 00 FETCH, 01 DECODE, 10 EXECUTE, 11 illegal.
- `pc_inc` in 1: advance the PC.
- `pc_jmp` in 1: load the PC from `operand`.
- `mem_read` in 1: RAM read strobe.
- `mem_data` in `DATA_W`: RAM read data, combinational from `mem_addr`.
- `mem_addr` out `ADDR_W`: RAM address (combinational).
- `opcode` out 4: IR high nibble.
- `operand` out `ADDR_W`: IR low field.
- `pc` out `ADDR_W`: current PC.
- `halted` out 1: sticky halt flag.
- `instr_count` out `CNT_W`: number of completed EXECUTE cycles, saturating.

## Operation
- Reset values: `pc`=0, IR=0 (so `opcode`=0 and `operand`=0), `halted`=0, `instr_count`=0. With `state`=00 after reset, `mem_addr`=0.
- Address mux:
  - `mem_addr` = `operand` when `state`==EXECUTE and `mem_read`=1.
  - Otherwise `mem_addr` = `pc`.
- IR load: on an edge with `state`==FETCH, `mem_read`=1 and `halted`=0, IR ← `mem_data`. In all other cases IR holds.
- PC update: applies only on an edge with `state`==EXECUTE and `halted`=0.
  - `pc_jmp`=1: PC ← `operand`. Jump has priority if `pc_inc` is also high.
  - Else `pc_inc`=1: PC ← PC+1, modulo 2^`ADDR_W` (15 → 0 wraps).
  - Else PC holds.
- `pc_inc` and `pc_jmp` are ignored in FETCH, DECODE and the illegal state.
- Halt:
  - On an edge with `state`==EXECUTE and `opcode`==4'b1111, `halted` ← 1.
  - `halted` stays set until reset; it is not cleared by any opcode.
  - While halted: PC and IR freeze, `instr_count` freezes, `mem_addr` follows the mux rule.
- Instruction counter: on each edge with `state`==EXECUTE and `halted`=0, `instr_count` increments. It saturates at all-ones. The HLT's own EXECUTE cycle is counted.
- Illegal `state` 11: no register changes. `mem_addr` = `pc`.

## Timing
- The control unit cycles FETCH → DECODE → EXECUTE, so one instruction takes 3 clocks.
- IR captures at the edge that ends FETCH. `opcode` and `operand` are valid throughout DECODE and EXECUTE.
- The PC changes at the edge that ends EXECUTE, so the next FETCH addresses the new PC with zero bubble.
- An operand data read happens in EXECUTE: `mem_addr` switches combinationally to `operand` in the same cycle, and `mem_data` is consumed by the datapath at the closing edge.
- `halted` rises at the edge ending the HLT's EXECUTE cycle and is visible from the following FETCH.
- Reset asserted mid-instruction: all outputs reach reset values without waiting for a clock edge. The first FETCH after reset deasserts reads address 0.

## Structure
- Shared package `sap1_pkg`:
  - state encodings `ST_FETCH`, `ST_DECODE`, `ST_EXECUTE`;
  - opcode constants `OP_LDA`…`OP_XOR`, `OP_JMP`, `OP_JZ`, `OP_OUT`, `OP_HLT`=4'b1111;
  - IR field slice positions.
- One sub-module, `program_counter`: `ADDR_W`-bit register with `inc`, `load` and `load_val` inputs, load priority, wrap-around, and async reset.
- IR, halt flag, counter and address mux stay in the top.

## Test plan
- Reset, then RAM[0]=0x1A, one FETCH: `mem_addr`=0 in FETCH; `opcode`=1 and `operand`=0xA from DECODE onward; in EXECUTE with `mem_read`=1, `mem_addr`=0xA; `pc`=1 after EXECUTE.
- PC at 15, EXECUTE with `pc_inc`=1 → `pc`=0. EXECUTE with `pc_inc`=1, `pc_jmp`=1, `operand`=5 → `pc`=5.
- `pc_inc`=1 asserted in FETCH and in DECODE → `pc` unchanged. `state`=11 with `mem_read`=1 → IR, PC and counter unchanged.
- Program LDA, ADD, HLT (RAM[2]=0xF0) → `halted`=1 after the 3rd EXECUTE. `instr_count`=3 and `pc`=2 stay frozen over 10 further cycles.
- Reset pulse during DECODE with `pc`=7 → `pc`, `opcode` and `instr_count` read 0 asynchronously. Refetch then starts at address 0.
- Run 300 instructions of a JMP-to-self loop → `instr_count` saturates at 255 and `pc` stays at the jump target.
